mem_stage_ooq: RTL and testbench

- Non-blocking successor to the single-entry memory stage: a DEPTH-entry in-order queue between EX and WB that lets several loads/stores wait for data_ok at once.
- Responses return in order and are matched to the oldest waiting entry. Load data is byte/half-extracted and sign-/zero-extended, and each entry retires to WB in program order.
- A WB cancel flushes the queue. Responses still owed to flushed requests are counted and dropped when they arrive.

---
 rtl/mem_stage_ooq.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_stage_ooq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ooq.sv
// In-order queue between EX and WB that lets several memory requests wait for
// data_ok at once; responses match the oldest waiting entry and retire in order.
module mem_stage_ooq #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned SIDE_WD = 150
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               es_to_ms_valid,
    output logic               ms_allowin,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_alu_result,
    input  logic [4:0]         in_dest,
    input  logic               in_gr_we,
    input  logic               in_mem_req,
    input  logic               in_load,
    input  logic               in_op_b,
    input  logic               in_op_h,
    input  logic               in_load_sign,
    input  logic [1:0]         in_last_two,
    input  logic               in_late,
    input  logic               in_flush_req,
    input  logic [SIDE_WD-1:0] in_side,
    input  logic               data_sram_data_ok,
    input  logic [31:0]        data_sram_rdata,
    output logic               req_credit,
    output logic               ms_cancel_es,
    input  logic               ws_cancel_ms,
    input  logic               ws_allowin,
    output logic               ms_to_ws_valid,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_result,
    output logic [4:0]         out_dest,
    output logic               out_gr_we,
    output logic               out_flush_req,
    output logic [SIDE_WD-1:0] out_side,
    input  logic [4:0]         q_rs1,
    input  logic [4:0]         q_rs2,
    output logic               f_hit1,
    output logic               f_blk1,
    output logic [31:0]        f_data1,
    output logic               f_hit2,
    output logic               f_blk2,
    output logic [31:0]        f_data2
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0]        pc;
        logic [4:0]         dest;
        logic               gr_we;
        logic               mem_req;
        logic               load;
        logic               op_b;
        logic               op_h;
        logic               load_sign;
        logic [1:0]         last_two;
        logic               late;
        logic               flush_req;
        logic [SIDE_WD-1:0] side;
    } entry_t;

    entry_t           ent_q    [DEPTH];
    entry_t           ent_d    [DEPTH];
    logic [31:0]      result_q [DEPTH];
    logic [31:0]      result_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, wait_cnt_q, wait_cnt_d, discard_cnt_q, discard_cnt_d;

    logic             enq, pop, resp_drop, resp_take, resp_hit;
    logic [PTR_W-1:0] resp_idx, scan_idx, fwd_idx;
    logic [DEPTH-1:0] flush_vec;
    logic [4:0]       fwd_rs   [2];
    logic             fwd_hit  [2];
    logic             fwd_blk  [2];
    logic [31:0]      fwd_data [2];

    function automatic logic [31:0] load_extract(input entry_t e, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (e.last_two)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = e.last_two[1] ? rdata[31:16] : rdata[15:0];
        if (e.op_b)      return {{24{e.load_sign & b[7]}}, b};
        else if (e.op_h) return {{16{e.load_sign & h[15]}}, h};
        else             return rdata;
    endfunction

    assign ms_allowin     = (count_q < CNT_W'(DEPTH)) && !ws_cancel_ms;
    assign enq            = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid = valid_q[head_q] && done_q[head_q] && !ws_cancel_ms;
    assign pop            = ms_to_ws_valid && ws_allowin;
    assign req_credit     = (SUM_W'(wait_cnt_q) + SUM_W'(discard_cnt_q)) < SUM_W'(DEPTH);
    assign ms_cancel_es   = |(valid_q & flush_vec);
    assign resp_drop      = data_sram_data_ok && (discard_cnt_q != '0);
    assign resp_take      = data_sram_data_ok && (discard_cnt_q == '0) && resp_hit;

    assign out_pc        = ent_q[head_q].pc;
    assign out_result    = result_q[head_q];
    assign out_dest      = ent_q[head_q].dest;
    assign out_gr_we     = ent_q[head_q].gr_we;
    assign out_flush_req = ent_q[head_q].flush_req;
    assign out_side      = ent_q[head_q].side;

    // Oldest valid entry still owed a response, scanning from head.
    always_comb begin
        resp_hit  = 1'b0;
        resp_idx  = '0;
        scan_idx  = '0;
        flush_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            flush_vec[i] = ent_q[i].flush_req;
            scan_idx = head_q + PTR_W'(i);
            if (!resp_hit && valid_q[scan_idx] && ent_q[scan_idx].mem_req && !done_q[scan_idx]) begin
                resp_hit = 1'b1;
                resp_idx = scan_idx;
            end
        end
    end

    // Forwarding: later matches in age order overwrite earlier, so the youngest wins.
    always_comb begin
        fwd_rs[0] = q_rs1;
        fwd_rs[1] = q_rs2;
        fwd_idx   = '0;
        for (int k = 0; k < 2; k++) begin
            fwd_hit[k]  = 1'b0;
            fwd_blk[k]  = 1'b0;
            fwd_data[k] = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fwd_idx = head_q + PTR_W'(i);
                if (valid_q[fwd_idx] && ent_q[fwd_idx].gr_we && (ent_q[fwd_idx].dest == fwd_rs[k])
                    && (fwd_rs[k] != 5'd0)) begin
                    fwd_hit[k]  = 1'b1;
                    fwd_blk[k]  = ent_q[fwd_idx].late || (ent_q[fwd_idx].load && !done_q[fwd_idx]);
                    fwd_data[k] = result_q[fwd_idx];
                end
            end
        end
    end

    assign f_hit1  = fwd_hit[0];
    assign f_blk1  = fwd_blk[0];
    assign f_data1 = fwd_data[0];
    assign f_hit2  = fwd_hit[1];
    assign f_blk2  = fwd_blk[1];
    assign f_data2 = fwd_data[1];

    always_comb begin
        valid_d       = valid_q;
        done_d        = done_q;
        ent_d         = ent_q;
        result_d      = result_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        wait_cnt_d    = wait_cnt_q;
        discard_cnt_d = discard_cnt_q;
        if (ws_cancel_ms) begin
            // Every response still owed to a flushed entry becomes a discard.
            valid_d       = '0;
            done_d        = '0;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            wait_cnt_d    = '0;
            discard_cnt_d = discard_cnt_q - CNT_W'(resp_drop) + wait_cnt_q - CNT_W'(resp_take);
        end else begin
            if (resp_drop) discard_cnt_d = discard_cnt_q - CNT_W'(1);
            if (resp_take) begin
                done_d[resp_idx] = 1'b1;
                if (ent_q[resp_idx].load)
                    result_d[resp_idx] = load_extract(ent_q[resp_idx], data_sram_rdata);
            end
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_W'(1);
            end
            if (enq) begin
                valid_d[tail_q]  = 1'b1;
                done_d[tail_q]   = !in_mem_req;
                result_d[tail_q] = in_alu_result;
                ent_d[tail_q]    = '{pc: in_pc, dest: in_dest, gr_we: in_gr_we, mem_req: in_mem_req,
                                     load: in_load, op_b: in_op_b, op_h: in_op_h,
                                     load_sign: in_load_sign, last_two: in_last_two, late: in_late,
                                     flush_req: in_flush_req, side: in_side};
                tail_d           = tail_q + PTR_W'(1);
            end
            count_d    = count_q + CNT_W'(enq) - CNT_W'(pop);
            wait_cnt_d = wait_cnt_q + CNT_W'(enq && in_mem_req) - CNT_W'(resp_take);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            done_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            wait_cnt_q    <= '0;
            discard_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            done_q        <= done_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            wait_cnt_q    <= wait_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        ent_q    <= ent_d;
        result_q <= result_d;
    end

    a_data_ok_expected: assert property (@(posedge clk) disable iff (reset)
        data_sram_data_ok |-> (discard_cnt_q != '0) || resp_hit);

endmodule

// File: tb/tb_mem_stage_ooq.sv
// Directed bench for mem_stage_ooq: ordering, extraction, full queue, flush discard,
// forwarding, exception squash and reset with traffic outstanding.
module tb_mem_stage_ooq;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned SIDE_WD = 150;

    logic               clk = 1'b0;
    logic               reset;
    logic               es_to_ms_valid, ms_allowin;
    logic [31:0]        in_pc, in_alu_result;
    logic [4:0]         in_dest;
    logic               in_gr_we, in_mem_req, in_load, in_op_b, in_op_h, in_load_sign;
    logic [1:0]         in_last_two;
    logic               in_late, in_flush_req;
    logic [SIDE_WD-1:0] in_side;
    logic               data_sram_data_ok;
    logic [31:0]        data_sram_rdata;
    logic               req_credit, ms_cancel_es, ws_cancel_ms, ws_allowin, ms_to_ws_valid;
    logic [31:0]        out_pc, out_result;
    logic [4:0]         out_dest;
    logic               out_gr_we, out_flush_req;
    logic [SIDE_WD-1:0] out_side;
    logic [4:0]         q_rs1, q_rs2;
    logic               f_hit1, f_blk1, f_hit2, f_blk2;
    logic [31:0]        f_data1, f_data2;

    int checks = 0;
    int errors = 0;

    mem_stage_ooq #(.DEPTH(DEPTH), .SIDE_WD(SIDE_WD)) dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .in_pc(in_pc), .in_alu_result(in_alu_result), .in_dest(in_dest), .in_gr_we(in_gr_we),
        .in_mem_req(in_mem_req), .in_load(in_load), .in_op_b(in_op_b), .in_op_h(in_op_h),
        .in_load_sign(in_load_sign), .in_last_two(in_last_two), .in_late(in_late),
        .in_flush_req(in_flush_req), .in_side(in_side),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .req_credit(req_credit), .ms_cancel_es(ms_cancel_es),
        .ws_cancel_ms(ws_cancel_ms), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .out_pc(out_pc), .out_result(out_result), .out_dest(out_dest), .out_gr_we(out_gr_we),
        .out_flush_req(out_flush_req), .out_side(out_side),
        .q_rs1(q_rs1), .q_rs2(q_rs2),
        .f_hit1(f_hit1), .f_blk1(f_blk1), .f_data1(f_data1),
        .f_hit2(f_hit2), .f_blk2(f_blk2), .f_data2(f_data2)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        in_pc             = '0;
        in_alu_result     = '0;
        in_dest           = '0;
        in_gr_we          = 1'b0;
        in_mem_req        = 1'b0;
        in_load           = 1'b0;
        in_op_b           = 1'b0;
        in_op_h           = 1'b0;
        in_load_sign      = 1'b0;
        in_last_two       = '0;
        in_late           = 1'b0;
        in_flush_req      = 1'b0;
        in_side           = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_cancel_ms      = 1'b0;
        q_rs1             = '0;
        q_rs2             = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dest,
                        input logic gr_we, input logic mem_req, input logic load,
                        input logic op_b, input logic op_h, input logic sgn,
                        input logic [1:0] lt, input logic flush);
        es_to_ms_valid = 1'b1;
        in_pc          = pc;
        in_alu_result  = alu;
        in_dest        = dest;
        in_gr_we       = gr_we;
        in_mem_req     = mem_req;
        in_load        = load;
        in_op_b        = op_b;
        in_op_h        = op_h;
        in_load_sign   = sgn;
        in_last_two    = lt;
        in_flush_req   = flush;
        in_side        = SIDE_WD'({pc, alu});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        nxt();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        ws_allowin = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_cancel_es !== 1'b0) begin errors++; $display("FAIL rst_cancel_es: got %b want 0", ms_cancel_es); end
        checks++; if (req_credit !== 1'b1) begin errors++; $display("FAIL rst_credit: got %b want 1", req_credit); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin: got %b want 1", ms_allowin); end
        checks++; if (f_hit1 !== 1'b0 || f_blk1 !== 1'b0) begin errors++; $display("FAIL rst_fwd: got hit=%b blk=%b want 0 0", f_hit1, f_blk1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ws_allowin = 1'b1;
        push(32'h100, 32'h1001, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        nxt();
        push(32'h104, 32'h1002, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
        nxt();
        push(32'h108, 32'h1000, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8081_F2FF;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b want 0", ms_to_ws_valid); end
        nxt();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_v0: got %b want 1", ms_to_ws_valid); end
        checks++; if (out_result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL b2b_lb: got %h want fffffff2", out_result); end
        checks++; if (out_dest !== 5'd1 || out_pc !== 32'h100) begin errors++; $display("FAIL b2b_head0: got dest=%0d pc=%h want 1 100", out_dest, out_pc); end
        nxt();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8081_F2FF;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", ms_to_ws_valid); end
        nxt();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || out_result !== 32'h0000_8081) begin errors++; $display("FAIL b2b_lhu: got v=%b %h want 1 00008081", ms_to_ws_valid, out_result); end
        checks++; if (out_dest !== 5'd2) begin errors++; $display("FAIL b2b_dest1: got %0d want 2", out_dest); end
        nxt();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8081_F2FF;
        nxt();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || out_result !== 32'h8081_F2FF) begin errors++; $display("FAIL b2b_lw: got v=%b %h want 1 8081f2ff", ms_to_ws_valid, out_result); end
        checks++; if (out_side !== SIDE_WD'({32'h108, 32'h1000})) begin errors++; $display("FAIL b2b_side: got %h want %h", out_side, SIDE_WD'({32'h108, 32'h1000})); end
        nxt();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0 || req_credit !== 1'b1) begin errors++; $display("FAIL b2b_drained: got v=%b credit=%b want 0 1", ms_to_ws_valid, req_credit); end
    endtask

    task automatic test_full_queue();
        do_reset();
        ws_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            push(32'h200 + 32'(4 * i), 32'h2000 + 32'(4 * i), 5'(8 + i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
            #2;
            checks++; if (ms_allowin !== 1'b1 || req_credit !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got allowin=%b credit=%b want 1 1", i, ms_allowin, req_credit); end
            nxt();
        end
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1122_3344;
        #2;
        checks++; if (ms_allowin !== 1'b0 || req_credit !== 1'b0) begin errors++; $display("FAIL full_block: got allowin=%b credit=%b want 0 0", ms_allowin, req_credit); end
        nxt();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || out_result !== 32'h1122_3344) begin errors++; $display("FAIL full_head: got v=%b %h want 1 11223344", ms_to_ws_valid, out_result); end
        checks++; if (ms_allowin !== 1'b0 || req_credit !== 1'b1) begin errors++; $display("FAIL full_poppending: got allowin=%b credit=%b want 0 1", ms_allowin, req_credit); end
        nxt();
        #2;
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", ms_allowin); end
    endtask

    task automatic test_flush();
        do_reset();
        ws_allowin = 1'b1;
        push(32'h300, 32'h3000, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        push(32'h304, 32'h3004, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        idle(); ws_cancel_ms = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555;
        #2;
        checks++; if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle: got allowin=%b v=%b want 0 0", ms_allowin, ms_to_ws_valid); end
        nxt();
        idle();
        push(32'h308, 32'h3008, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #2;
        checks++; if (ms_allowin !== 1'b1 || req_credit !== 1'b1) begin errors++; $display("FAIL flush_after: got allowin=%b credit=%b want 1 1", ms_allowin, req_credit); end
        nxt();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD;
        nxt();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got v=%b result=%h want v=0", ms_to_ws_valid, out_result); end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234;
        nxt();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || out_result !== 32'h1234 || out_dest !== 5'd3) begin errors++; $display("FAIL flush_fresh: got v=%b %h dest=%0d want 1 00001234 3", ms_to_ws_valid, out_result, out_dest); end
        nxt();
    endtask

    task automatic test_forward();
        do_reset();
        ws_allowin = 1'b0;
        push(32'h400, 32'h7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        idle();
        push(32'h404, 32'h4000, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        q_rs1 = 5'd5;
        #2;
        checks++; if (f_hit1 !== 1'b1 || f_blk1 !== 1'b0 || f_data1 !== 32'h7) begin errors++; $display("FAIL fwd_alu: got hit=%b blk=%b %h want 1 0 7", f_hit1, f_blk1, f_data1); end
        nxt();
        idle(); q_rs1 = 5'd5; q_rs2 = 5'd0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h99;
        #2;
        checks++; if (f_hit1 !== 1'b1 || f_blk1 !== 1'b1) begin errors++; $display("FAIL fwd_pending: got hit=%b blk=%b want 1 1", f_hit1, f_blk1); end
        checks++; if (f_hit2 !== 1'b0 || f_blk2 !== 1'b0 || f_data2 !== 32'h0) begin errors++; $display("FAIL fwd_r0: got hit=%b blk=%b %h want 0 0 0", f_hit2, f_blk2, f_data2); end
        nxt();
        idle(); q_rs1 = 5'd5; q_rs2 = 5'd5;
        #2;
        checks++; if (f_hit1 !== 1'b1 || f_blk1 !== 1'b0 || f_data1 !== 32'h99) begin errors++; $display("FAIL fwd_done: got hit=%b blk=%b %h want 1 0 99", f_hit1, f_blk1, f_data1); end
        checks++; if (f_data2 !== 32'h99) begin errors++; $display("FAIL fwd_port2: got %h want 99", f_data2); end
        nxt();
        ws_allowin = 1'b1;
    endtask

    task automatic test_exception();
        do_reset();
        ws_allowin = 1'b1;
        push(32'h500, 32'h5000, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        push(32'h1c0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        #2;
        checks++; if (ms_cancel_es !== 1'b0) begin errors++; $display("FAIL exc_none: got %b want 0", ms_cancel_es); end
        nxt();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_5555;
        #2;
        checks++; if (ms_cancel_es !== 1'b1 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL exc_queued: got cancel=%b v=%b want 1 0", ms_cancel_es, ms_to_ws_valid); end
        nxt();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || out_flush_req !== 1'b0 || out_result !== 32'hAAAA_5555) begin errors++; $display("FAIL exc_load: got v=%b fr=%b %h want 1 0 aaaa5555", ms_to_ws_valid, out_flush_req, out_result); end
        checks++; if (ms_cancel_es !== 1'b1) begin errors++; $display("FAIL exc_hold: got %b want 1", ms_cancel_es); end
        nxt();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || out_flush_req !== 1'b1 || out_pc !== 32'h1c0) begin errors++; $display("FAIL exc_head: got v=%b fr=%b pc=%h want 1 1 1c0", ms_to_ws_valid, out_flush_req, out_pc); end
        nxt();
        #2;
        checks++; if (ms_cancel_es !== 1'b0 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL exc_gone: got cancel=%b v=%b want 0 0", ms_cancel_es, ms_to_ws_valid); end
    endtask

    task automatic test_reset_outstanding();
        do_reset();
        ws_allowin = 1'b0;
        push(32'h600, 32'h6000, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        push(32'h604, 32'h6004, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        idle(); ws_cancel_ms = 1'b1;
        nxt();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD;
        push(32'h608, 32'h6008, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        idle();
        push(32'h60c, 32'h600c, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        idle();
        push(32'h610, 32'h70, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        nxt();
        idle(); q_rs1 = 5'd7;
        push(32'h614, 32'h6014, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #2;
        checks++; if (req_credit !== 1'b1 || ms_cancel_es !== 1'b1 || f_hit1 !== 1'b1) begin errors++; $display("FAIL rsto_pre: got credit=%b cancel=%b hit=%b want 1 1 1", req_credit, ms_cancel_es, f_hit1); end
        nxt();
        idle(); q_rs1 = 5'd7;
        #2;
        checks++; if (req_credit !== 1'b0) begin errors++; $display("FAIL rsto_nocredit: got %b want 0", req_credit); end
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        idle(); q_rs1 = 5'd7; ws_allowin = 1'b1;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_cancel_es !== 1'b0) begin errors++; $display("FAIL rsto_out: got v=%b cancel=%b want 0 0", ms_to_ws_valid, ms_cancel_es); end
        checks++; if (f_hit1 !== 1'b0 || f_blk1 !== 1'b0 || f_data1 !== 32'h0) begin errors++; $display("FAIL rsto_fwd: got hit=%b blk=%b %h want 0 0 0", f_hit1, f_blk1, f_data1); end
        checks++; if (req_credit !== 1'b1 || ms_allowin !== 1'b1) begin errors++; $display("FAIL rsto_credit: got credit=%b allowin=%b want 1 1", req_credit, ms_allowin); end
        push(32'h700, 32'h7000, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        nxt();
        idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h77;
        nxt();
        idle();
        #2;
        checks++; if (ms_to_ws_valid !== 1'b1 || out_result !== 32'h77) begin errors++; $display("FAIL rsto_nodiscard: got v=%b %h want 1 00000077", ms_to_ws_valid, out_result); end
        nxt();
    endtask

    initial begin
        idle();
        reset      = 1'b1;
        ws_allowin = 1'b1;
        test_reset();
        test_back_to_back();
        test_full_queue();
        test_flush();
        test_forward();
        test_exception();
        test_reset_outstanding();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
